alu_share_ctrl: RTL and testbench
=================================

Name: alu_share_ctrl

Overview:
- Round-robin controller that shares one 32-bit ALU between two requesters (req0, req1).
- Requesters submit A, B and ALUOp through a valid/ready handshake. The controller drives the ALU operands, captures the result and returns it through a per-requester response handshake.
- Sits between the ALU (instantiated alongside it) and the two client units of the datapath.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- OPW, 3, ALUOp width.
- OP_MAX, 3'b101, highest defined opcode (0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra); codes above OP_MAX are flagged as errors.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  controller accepts requester 0 this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_op  input  OPW  requester 0 ALUOp.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp0_valid  output  1  result for requester 0 available.
- rsp0_ready  input  1  requester 0 consumes its result.
- rsp1_valid  output  1  result for requester 1 available.
- rsp1_ready  input  1  requester 1 consumes its result.
- rsp_data  output  WIDTH  result; shared, meaningful only while a rsp*_valid is high.
- rsp_err  output  1  opcode of the returned operation was above OP_MAX; qualified by rsp*_valid.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_op  output  OPW  to ALU ALUOp.
- alu_c  input  WIDTH  from ALU C; the ALU is combinational.

Behaviour:
- Reset values: state IDLE; req0_ready/req1_ready/rsp0_valid/rsp1_valid/rsp_err = 0; rsp_data = 0; alu_a/alu_b/alu_op = 0; last = 1, so requester 0 wins first.
- States: IDLE, EXEC, RESP.
- IDLE, grant (combinational):
  - Only one valid: that one is granted.
  - Both valid: the one not equal to `last` is granted.
  - reqN_ready = (state == IDLE) && grant == N. The two readys are never high together.
- IDLE, accept edge (valid & ready):
  - Latch a, b, op and id into internal registers.
  - state -> EXEC.
- EXEC:
  - alu_a/alu_b/alu_op are driven from the latched registers; they stay constant through EXEC and RESP.
  - Next edge: rsp_data <= alu_c; rsp_err <= (op > OP_MAX); rsp<id>_valid <= 1; state -> RESP.
- RESP:
  - rsp<id>_valid, rsp_data and rsp_err hold until the edge with rsp<id>_ready = 1.
  - At that edge: rsp_valid <= 0; last <= id; state -> IDLE.
  - rsp_ready of the non-owning requester is ignored.
- Latency:
  - Accept at edge N; rsp valid from edge N+1, so result visible 1 cycle after accept.
  - With rsp_ready already high, IDLE is re-entered at edge N+2.
  - Throughput: 1 op per 3 cycles, with no overlap between accept and response.
- No new request is accepted outside IDLE. A requester holds valid and operands until ready; the controller never drops a pending valid.
- Width rules:
  - Result is exactly WIDTH bits from the ALU; the controller does not modify it.
  - Undefined ops still execute (ALU returns 0) and set rsp_err.
- Fairness:
  - Under continuous contention, grants alternate 0,1,0,1.
  - A single active requester is granted back-to-back.
  - `last` updates only on response completion, never on accept.
- Reset asserted mid-operation (EXEC or RESP): the in-flight result is discarded and all outputs return to reset values immediately (asynchronously). No response is produced after reset deasserts.
- Valid deasserted by a requester while not yet accepted: legal; arbitration re-evaluates each IDLE cycle.

Test Plan:
- Reset then single request: req0 a=5, b=3, op=1 -> req0_ready same cycle; rsp0_valid 1 cycle after accept; rsp_data=2; rsp_err=0; back to IDLE after rsp0_ready.
- Contention: both valid continuously, req0 op=0 a=1 b=1, req1 op=2 a=0xF0 b=0x3C -> grant order 0,1,0,1; rsp_data alternates 2 and 0x30; readys never both high.
- Response backpressure: req1 a=0x80000000, b=4, op=5, rsp1_ready low for 5 cycles -> rsp1_valid, rsp_data=0xF8000000 and alu_* all stable 5 cycles; req0_valid meanwhile gets no ready.
- Illegal op: req0 op=3'b111 -> rsp0_valid, rsp_data=0, rsp_err=1.
- Reset mid-op: reset pulses during EXEC -> all outputs 0 immediately; no rsp valid afterwards; next request from req1 alone is served normally (first grant goes to req0 if both are valid).
- Single requester back-to-back: req1 only, ops 4 then 4 with a=0x100, b=4 -> both served consecutively with rsp_data=0x10; each accept 3 cycles apart.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU between two requesters.
// Accept -> result valid next cycle; response held until the owner's rsp_ready, no new accept until then.
module alu_share_ctrl #(
  parameter int             WIDTH  = 32,
  parameter int             OPW    = 3,
  parameter logic [OPW-1:0] OP_MAX = 3'b101
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  logic             r_last;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OPW-1:0]   r_op;
  logic [WIDTH-1:0] r_data;
  logic             r_err;
  logic             r_vld0;
  logic             r_vld1;

  logic w_gnt0;
  logic w_gnt1;
  logic w_acc0;
  logic w_acc1;
  logic w_rsp_done;

  // Requester 1 wins a tie only when requester 0 was served last.
  assign w_gnt1 = req1_valid && (!req0_valid || (r_last == 1'b0));
  assign w_gnt0 = req0_valid && !w_gnt1;

  // Gated by reset so the readys read as 0 while reset is held.
  assign req0_ready = !reset && (r_state == IDLE) && w_gnt0;
  assign req1_ready = !reset && (r_state == IDLE) && w_gnt1;

  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;
  assign w_rsp_done = r_id ? rsp1_ready : rsp0_ready;

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp_data   = r_data;
  assign rsp_err    = r_err;
  assign rsp0_valid = r_vld0;
  assign rsp1_valid = r_vld1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_vld0  <= 1'b0;
      r_vld1  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_a     <= w_acc1 ? req1_a  : req0_a;
            r_b     <= w_acc1 ? req1_b  : req0_b;
            r_op    <= w_acc1 ? req1_op : req0_op;
            r_id    <= w_acc1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_data  <= alu_c;
          r_err   <= (r_op > OP_MAX);
          r_vld0  <= !r_id;
          r_vld1  <= r_id;
          r_state <= RESP;
        end
        RESP: begin
          if (w_rsp_done) begin
            r_vld0  <= 1'b0;
            r_vld1  <= 1'b0;
            r_last  <= r_id;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl with a behavioural combinational ALU attached.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  alu_share_ctrl dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    alu_c = 32'd0;
    case (alu_op)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_a & alu_b;
      3'd3: alu_c = alu_a | alu_b;
      3'd4: alu_c = alu_a >> alu_b[4:0];
      3'd5: alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_c = 32'd0;
    endcase
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (id) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " rdy0"}, {31'd0, req0_ready}, 32'd0);
    chk({name, " rdy1"}, {31'd0, req1_ready}, 32'd0);
    chk({name, " rspv"}, {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
    chk({name, " data"}, rsp_data, 32'd0);
    chk({name, " err"}, {31'd0, rsp_err}, 32'd0);
    chk({name, " alu_a"}, alu_a, 32'd0);
    chk({name, " alu_b"}, alu_b, 32'd0);
    chk({name, " alu_op"}, {29'd0, alu_op}, 32'd0);
  endtask

  initial begin
    int acc[2];
    int n;
    logic exp_id;

    vecs[0] = '{1'b0, 32'd5,          32'd3,  3'd1, 32'd2,          1'b0};
    vecs[1] = '{1'b1, 32'h0000_00F0,  32'h3C, 3'd2, 32'h0000_0030,  1'b0};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF,  32'd1,  3'd0, 32'h0000_0000,  1'b0};
    vecs[3] = '{1'b1, 32'h0000_00F0,  32'h0F, 3'd3, 32'h0000_00FF,  1'b0};
    vecs[4] = '{1'b0, 32'h0000_0100,  32'd4,  3'd4, 32'h0000_0010,  1'b0};
    vecs[5] = '{1'b1, 32'h8000_0000,  32'd4,  3'd5, 32'hF800_0000,  1'b0};
    vecs[6] = '{1'b0, 32'd1,          32'd2,  3'd7, 32'h0000_0000,  1'b1};
    vecs[7] = '{1'b1, 32'd9,          32'd9,  3'd6, 32'h0000_0000,  1'b1};
    vecs[8] = '{1'b1, 32'd0,          32'd1,  3'd1, 32'hFFFF_FFFF,  1'b0};

    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    chk_all_zero("reset");
    req0_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single-requester table: accept, one cycle of EXEC, response, back to IDLE.
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      chk($sformatf("v%0d ready", i), {30'd0, req1_ready, req0_ready},
          vecs[i].id ? 32'd2 : 32'd1);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      chk($sformatf("v%0d alu_a", i), alu_a, vecs[i].a);
      chk($sformatf("v%0d alu_op", i), {29'd0, alu_op}, {29'd0, vecs[i].op});
      chk($sformatf("v%0d exec rspv", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      tick(); #1;
      chk($sformatf("v%0d rspv", i), {30'd0, rsp1_valid, rsp0_valid},
          vecs[i].id ? 32'd2 : 32'd1);
      chk($sformatf("v%0d data", i), rsp_data, vecs[i].exp);
      chk($sformatf("v%0d err", i), {31'd0, rsp_err}, {31'd0, vecs[i].err});
      tick(); #1;
      chk($sformatf("v%0d idle rspv", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end

    // Continuous contention: last completed was req1, so grants go 0,1,0,1.
    drive(1'b0, 32'd1, 32'd1, 3'd0);
    drive(1'b1, 32'hF0, 32'h3C, 3'd2);
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_id = (i % 2 == 1);
      chk($sformatf("cont%0d grant", i), {30'd0, req1_ready, req0_ready},
          exp_id ? 32'd2 : 32'd1);
      tick(); #1;
      chk($sformatf("cont%0d exec rdy", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      tick(); #1;
      chk($sformatf("cont%0d rspv", i), {30'd0, rsp1_valid, rsp0_valid},
          exp_id ? 32'd2 : 32'd1);
      chk($sformatf("cont%0d data", i), rsp_data, exp_id ? 32'h30 : 32'd2);
      tick(); #1;
    end

    // Response backpressure on req1; req0 waits and rsp0_ready is ignored.
    req0_valid = 1'b0;
    drive(1'b1, 32'h8000_0000, 32'd4, 3'd5);
    #1;
    chk("bp ready1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    drive(1'b0, 32'd7, 32'd7, 3'd0);
    rsp1_ready = 1'b0;
    rsp0_ready = 1'b1;
    tick(); #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d rsp1v", i), {31'd0, rsp1_valid}, 32'd1);
      chk($sformatf("bp%0d data", i), rsp_data, 32'hF800_0000);
      chk($sformatf("bp%0d alu", i), alu_a ^ alu_b ^ {29'd0, alu_op},
          32'h8000_0000 ^ 32'd4 ^ 32'd5);
      chk($sformatf("bp%0d rdy0", i), {31'd0, req0_ready}, 32'd0);
      tick(); #1;
    end
    rsp1_ready = 1'b1;
    tick(); #1;
    chk("bp release rsp1v", {31'd0, rsp1_valid}, 32'd0);
    chk("bp release rdy0", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    #1;
    chk("withdraw rdy0", {31'd0, req0_ready}, 32'd0);
    tick(); #1;
    chk("withdraw no exec", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("withdraw alu_a", alu_a, 32'h8000_0000);

    // Reset during EXEC discards the operation.
    drive(1'b0, 32'd1, 32'd1, 3'd0);
    #1;
    tick();
    req0_valid = 1'b0;
    #1;
    chk("midrst pre alu_a", alu_a, 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("midrst");
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk($sformatf("postrst%0d rspv", i), {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    drive(1'b0, 32'd1, 32'd1, 3'd0);
    drive(1'b1, 32'h100, 32'd4, 3'd4);
    #1;
    chk("postrst first grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    #1;

    // req1 alone, back-to-back: accepts 3 cycles apart.
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!req1_ready && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("b2b%0d ready seen", k), {31'd0, req1_ready}, 32'd1);
      acc[k] = cyc;
      tick(); tick(); #1;
      chk($sformatf("b2b%0d rsp1v", k), {31'd0, rsp1_valid}, 32'd1);
      chk($sformatf("b2b%0d data", k), rsp_data, 32'h10);
      if (k == 1) req1_valid = 1'b0;
      tick();
    end
    chk("b2b spacing", acc[1] - acc[0], 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
